// File: rtl/coinc_frame_scheduler.sv
// Round-robin arbiter that frames one channel's count word at a time for a shared
// UART byte transmitter: header {SYNC_NIBBLE, ch}, payload LSB byte first, XOR checksum.
module coinc_frame_scheduler #(
  parameter int         N_CH        = 4,
  parameter int         WORD_BYTES  = 4,
  parameter logic [3:0] SYNC_NIBBLE = 4'hA
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [N_CH-1:0]                i_req,
  input  logic [N_CH*8*WORD_BYTES-1:0]   i_word_in,
  output logic [N_CH-1:0]                o_ack,
  output logic [7:0]                     o_tx_data,
  output logic                           o_tx_valid,
  input  logic                           i_tx_ready,
  output logic                           o_busy,
  output logic [3:0]                     o_cur_ch
);

  localparam int WW = 8 * WORD_BYTES;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2,
    S_CSUM = 2'd3
  } state_t;

  function automatic logic [7:0] f_csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t          r_state, w_state_nxt;
  logic [WW-1:0]   r_word, w_word_nxt, w_word_sel;
  logic [7:0]      r_csum, w_csum_nxt;
  logic [7:0]      r_tx_data, w_tx_data_nxt;
  logic            r_tx_valid, w_tx_valid_nxt;
  logic [2:0]      r_idx, w_idx_nxt;
  logic [3:0]      r_last, w_last_nxt;
  logic [3:0]      r_cur_ch, w_cur_ch_nxt;
  logic [N_CH-1:0] r_ack, w_ack_nxt;
  logic            r_busy;
  logic            w_found;
  logic [3:0]      w_gnt;
  logic            w_xfer;

  assign w_xfer = r_tx_valid & i_tx_ready;

  // Round-robin pick: first requester scanning from last_grant+1 upward, wrapping.
  always_comb begin
    w_found    = 1'b0;
    w_gnt      = 4'h0;
    w_word_sel = {WW{1'b0}};
    for (int k = 1; k <= N_CH; k++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (!w_found && i_req[c] && (((int'(r_last) + k) % N_CH) == c)) begin
          w_found    = 1'b1;
          w_gnt      = 4'(c);
          w_word_sel = i_word_in[c*WW +: WW];
        end else begin
          w_found = w_found;
        end
      end
    end
  end

  // Frame sequencing and next values of every registered output.
  always_comb begin
    w_state_nxt    = r_state;
    w_word_nxt     = r_word;
    w_csum_nxt     = r_csum;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_idx_nxt      = r_idx;
    w_last_nxt     = r_last;
    w_cur_ch_nxt   = r_cur_ch;
    w_ack_nxt      = {N_CH{1'b0}};
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_word_nxt     = w_word_sel;
          w_cur_ch_nxt   = w_gnt;
          w_last_nxt     = w_gnt;
          for (int c = 0; c < N_CH; c++) begin
            w_ack_nxt[c] = (w_gnt == 4'(c));
          end
          w_tx_valid_nxt = 1'b1;
          w_tx_data_nxt  = {SYNC_NIBBLE, w_gnt};
          w_csum_nxt     = {SYNC_NIBBLE, w_gnt};
          w_state_nxt    = S_HDR;
        end else begin
          w_tx_valid_nxt = 1'b0;
          w_tx_data_nxt  = 8'h00;
        end
      end
      S_HDR: begin
        if (w_xfer) begin
          w_tx_data_nxt = r_word[7:0];
          w_csum_nxt    = f_csum_step(r_csum, r_word[7:0]);
          w_word_nxt    = r_word >> 4'd8;
          w_idx_nxt     = 3'd0;
          w_state_nxt   = S_PAY;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_PAY: begin
        if (w_xfer && (r_idx == 3'(WORD_BYTES - 1))) begin
          w_tx_data_nxt = r_csum;
          w_state_nxt   = S_CSUM;
        end else if (w_xfer) begin
          w_idx_nxt     = r_idx + 3'd1;
          w_tx_data_nxt = r_word[7:0];
          w_csum_nxt    = f_csum_step(r_csum, r_word[7:0]);
          w_word_nxt    = r_word >> 4'd8;
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_CSUM: begin
        if (w_xfer) begin
          w_tx_valid_nxt = 1'b0;
          w_tx_data_nxt  = 8'h00;
          w_state_nxt    = S_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_tx_valid_nxt = 1'b0;
        w_state_nxt    = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_word     <= {WW{1'b0}};
      r_csum     <= 8'h00;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_idx      <= 3'd0;
      r_last     <= 4'(N_CH - 1);
      r_cur_ch   <= 4'h0;
      r_ack      <= {N_CH{1'b0}};
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_word     <= w_word_nxt;
      r_csum     <= w_csum_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_idx      <= w_idx_nxt;
      r_last     <= w_last_nxt;
      r_cur_ch   <= w_cur_ch_nxt;
      r_ack      <= w_ack_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign o_ack      = r_ack;
  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_busy     = r_busy;
  assign o_cur_ch   = r_cur_ch;

endmodule

// File: tb/tb_coinc_frame_scheduler.sv
// Bench for coinc_frame_scheduler: vector table of single-channel frames plus
// hand-written sequences for round-robin, back-pressure, reset abort and word capture.
module tb_coinc_frame_scheduler;

  localparam int N_CH = 4;
  localparam int WB   = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] word_in;
  logic [3:0]   ack;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic [3:0]   cur_ch;

  always #5 clk = ~clk;

  coinc_frame_scheduler #(.N_CH(N_CH), .WORD_BYTES(WB), .SYNC_NIBBLE(4'hA)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_word_in  (word_in),
    .o_ack      (ack),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_busy     (busy),
    .o_cur_ch   (cur_ch)
  );

  typedef struct {
    logic [3:0]  ch;
    logic [31:0] word;
    logic [7:0]  csum;
  } vec_t;

  int         n_checks = 0;
  int         n_errors = 0;
  int         nxfer    = 0;
  int         cyc      = 0;
  int         ack_cnt[4];
  logic [7:0] sb[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: monitor at the falling edge, then return 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (prev_hold) begin
      chk("hold_valid", 64'(tx_valid), 64'd1);
      chk("hold_data", 64'(tx_data), 64'(prev_data));
    end
    if (ack != 4'h0) begin
      chk("ack_onehot", 64'($onehot(ack)), 64'd1);
      for (int c = 0; c < 4; c++) ack_cnt[c] += int'(ack[c]);
    end
    if (!rst && tx_valid && tx_ready) begin
      nxfer++;
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_byte: got %0h expected none", tx_data);
      end else begin
        chk("byte", 64'(tx_data), 64'(sb.pop_front()));
      end
    end
    prev_hold = tx_valid && !tx_ready && !rst;
    prev_data = tx_data;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_csum(input logic [3:0] ch, input logic [31:0] w);
    logic [7:0] c;
    c = {4'hA, ch};
    for (int b = 0; b < WB; b++) c = c ^ w[8*b +: 8];
    return c;
  endfunction

  task automatic push_frame(input logic [3:0] ch, input logic [31:0] w, input logic [7:0] cs);
    sb.push_back({4'hA, ch});
    for (int b = 0; b < WB; b++) sb.push_back(w[8*b +: 8]);
    sb.push_back(cs);
  endtask

  task automatic wait_ack(input string name, input logic [3:0] exp_mask);
    int i;
    i = 0;
    do begin
      step();
      i++;
    end while (ack == 4'h0 && i < 50);
    chk(name, 64'(ack), 64'(exp_mask));
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while ((sb.size() != 0 || busy) && i < 200) begin
      step();
      i++;
    end
    chk({name, "_queue_left"}, 64'(sb.size()), 64'd0);
    chk({name, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    sb.delete();
  endtask

  vec_t       tbl[6];
  logic [3:0] pat;
  int         t_cyc, t_prev, t_x0, a0;

  initial begin
    tbl[0] = '{ch: 4'd2, word: 32'h11223344, csum: 8'hE6};
    tbl[1] = '{ch: 4'd0, word: 32'h00000000, csum: 8'hA0};
    tbl[2] = '{ch: 4'd1, word: 32'hFFFFFFFF, csum: 8'hA1};
    tbl[3] = '{ch: 4'd3, word: 32'h000000FF, csum: 8'h5C};
    tbl[4] = '{ch: 4'd0, word: 32'h12345678, csum: 8'hA8};
    tbl[5] = '{ch: 4'd1, word: 32'hDEADBEEF, csum: 8'h83};
    for (int c = 0; c < 4; c++) ack_cnt[c] = 0;

    req = 4'h0; word_in = 128'h0; tx_ready = 1'b1; rst = 1'b1;
    do_reset();
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_valid", 64'(tx_valid), 64'd0);
    chk("rst_data", 64'(tx_data), 64'h00);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cur_ch", 64'(cur_ch), 64'd0);
    repeat (3) step();
    chk("idle_valid", 64'(tx_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    for (int v = 0; v < 6; v++) begin
      req = 4'h0;
      req[tbl[v].ch] = 1'b1;
      word_in = 128'h0;
      word_in[32*tbl[v].ch +: 32] = tbl[v].word;
      push_frame(tbl[v].ch, tbl[v].word, tbl[v].csum);
      wait_ack("vec_ack", 4'(1 << tbl[v].ch));
      chk("vec_hdr", 64'(tx_data), 64'({4'hA, tbl[v].ch}));
      chk("vec_valid", 64'(tx_valid), 64'd1);
      chk("vec_cur_ch", 64'(cur_ch), 64'(tbl[v].ch));
      req = 4'h0;
      t_x0 = nxfer;
      step();
      chk("vec_ack_pulse", 64'(ack), 64'd0);
      drain("vec");
      chk("vec_len", 64'(nxfer - t_x0), 64'd6);
    end

    do_reset();
    word_in = {32'hA3A3A3A3, 32'h02020202, 32'h01010101, 32'h00000000};
    for (int f = 0; f < 5; f++) begin
      push_frame(4'(f % 4), word_in[32*(f%4) +: 32], model_csum(4'(f % 4), word_in[32*(f%4) +: 32]));
    end
    req = 4'b1111;
    t_prev = 0;
    for (int f = 0; f < 5; f++) begin
      wait_ack("rr_ack", 4'(1 << (f % 4)));
      t_cyc = cyc;
      if (f > 0) chk("rr_period", 64'(t_cyc - t_prev), 64'd7);
      t_prev = t_cyc;
    end
    req = 4'h0;
    drain("rr");

    word_in = 128'h0;
    word_in[63:32] = 32'hC0FFEE42;
    push_frame(4'd1, 32'hC0FFEE42, model_csum(4'd1, 32'hC0FFEE42));
    req = 4'b0010;
    wait_ack("bp_ack", 4'b0010);
    req = 4'h0;
    t_x0 = nxfer;
    pat = 4'b1001;
    for (int p = 0; p < 200 && (sb.size() != 0 || busy); p++) begin
      tx_ready = pat[p % 4];
      step();
    end
    tx_ready = 1'b1;
    chk("bp_len", 64'(nxfer - t_x0), 64'd6);
    chk("bp_queue_left", 64'(sb.size()), 64'd0);
    chk("bp_busy_end", 64'(busy), 64'd0);

    word_in = 128'h0;
    word_in[127:96] = 32'h55667788;
    push_frame(4'd3, 32'h55667788, model_csum(4'd3, 32'h55667788));
    req = 4'b1000;
    wait_ack("abort_ack", 4'b1000);
    req = 4'h0;
    t_x0 = nxfer;
    for (int i = 0; i < 50 && (nxfer - t_x0) < 3; i++) step();
    chk("abort_pre_xfers", 64'(nxfer - t_x0), 64'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    chk("abort_valid", 64'(tx_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    word_in[31:0] = 32'h0BADF00D;
    push_frame(4'd0, 32'h0BADF00D, model_csum(4'd0, 32'h0BADF00D));
    req = 4'b1001;
    wait_ack("abort_first_ack", 4'b0001);
    chk("abort_first_hdr", 64'(tx_data), 64'hA0);
    req = 4'h0;
    drain("abort");

    a0 = ack_cnt[0];
    word_in = 128'h0;
    word_in[31:0] = 32'h13579BDF;
    push_frame(4'd0, 32'h13579BDF, model_csum(4'd0, 32'h13579BDF));
    req = 4'b0001;
    wait_ack("cap_ack", 4'b0001);
    req = 4'h0;
    step();
    word_in[31:0] = 32'hFFFF0000;
    drain("cap");
    repeat (4) step();
    chk("cap_ack_count", 64'(ack_cnt[0] - a0), 64'd1);
    chk("cap_idle_valid", 64'(tx_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
